// File: rtl/q_update_unit.sv
// q_update_unit: temporal-difference update engine for the Q-table.
// Captures one RAM read (Q(s,a), next-state row, reward), serially finds
// max Q(s',.), computes Q + ALPHA*(R + GAMMA*maxQ' - Q) in signed fixed
// point with output saturation, and issues a single write-back strobe.
module q_update_unit #(
    parameter int                    DATA_WIDTH    = 16,
    parameter int                    FRAC_BITS     = 8,
    parameter int                    ACTIONS       = 4,
    parameter int                    ACTIONS_WIDTH = 2,
    parameter int                    STATES_WIDTH  = 4,
    parameter logic [DATA_WIDTH-1:0] ALPHA         = 16'h0080,
    parameter logic [DATA_WIDTH-1:0] GAMMA         = 16'h00E6
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_valid,
    input  logic [DATA_WIDTH-1:0]           i_q,
    input  logic [DATA_WIDTH*ACTIONS-1:0]   i_next_q,
    input  logic [DATA_WIDTH-1:0]           i_reward,
    input  logic [STATES_WIDTH-1:0]         i_st,
    input  logic [ACTIONS_WIDTH-1:0]        i_at,
    output logic                            o_we,
    output logic [STATES_WIDTH-1:0]         o_st,
    output logic [ACTIONS_WIDTH-1:0]        o_at,
    output logic [DATA_WIDTH-1:0]           o_data,
    output logic [ACTIONS_WIDTH-1:0]        o_max_action,
    output logic                            o_busy,
    output logic                            o_overrun
);

    // td carries two guard bits: R + p - Q spans up to three full-scale words.
    localparam int TW = DATA_WIDTH + 2;
    localparam int PW = DATA_WIDTH + TW;
    localparam int GW = 2 * DATA_WIDTH;

    localparam logic signed [DATA_WIDTH-1:0] ALPHA_S = ALPHA;
    localparam logic signed [DATA_WIDTH-1:0] GAMMA_S = GAMMA;
    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [ACTIONS_WIDTH-1:0] LAST = ACTIONS_WIDTH'(ACTIONS - 1);

    typedef enum logic [2:0] {IDLE, MAX, TD, SCALE, WRITE} state_t;

    state_t                           state;
    logic [ACTIONS_WIDTH-1:0]         cnt;
    logic [ACTIONS_WIDTH-1:0]         idx;
    logic signed [DATA_WIDTH-1:0]     q_r;
    logic signed [DATA_WIDTH-1:0]     r_r;
    logic signed [DATA_WIDTH-1:0]     max_q;
    logic [DATA_WIDTH*ACTIONS-1:0]    nq_r;
    logic [STATES_WIDTH-1:0]          st_r;
    logic [ACTIONS_WIDTH-1:0]         at_r;
    logic signed [TW-1:0]             td_r;
    logic [DATA_WIDTH-1:0]            res_r;

    logic signed [DATA_WIDTH-1:0]     row [ACTIONS];
    logic signed [GW-1:0]             gprod;
    logic signed [TW-1:0]             p_t;
    logic signed [TW-1:0]             td_next;
    logic signed [PW-1:0]             aprod;
    logic signed [PW-1:0]             sum;
    logic [DATA_WIDTH-1:0]            sat;

    // Unpack the captured next-state row; action 0 lives in the MSB slice.
    for (genvar k = 0; k < ACTIONS; k++) begin : g_row
        assign row[k] = nq_r[(ACTIONS-1-k)*DATA_WIDTH +: DATA_WIDTH];
    end

    // TD error and scaled, saturated update; shifts floor toward -inf.
    always_comb begin
        gprod   = GW'(GAMMA_S) * GW'(max_q);
        p_t     = TW'(gprod >>> FRAC_BITS);
        td_next = TW'(r_r) + p_t - TW'(q_r);
        aprod   = PW'(ALPHA_S) * PW'(td_r);
        sum     = PW'(q_r) + (aprod >>> FRAC_BITS);
        sat     = sum[DATA_WIDTH-1:0];
        if (sum > SAT_MAX)      sat = SAT_MAX[DATA_WIDTH-1:0];
        else if (sum < SAT_MIN) sat = SAT_MIN[DATA_WIDTH-1:0];
    end

    // Update sequencer with registered outputs; busy drops one cycle after the write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            q_r          <= '0;
            r_r          <= '0;
            max_q        <= '0;
            nq_r         <= '0;
            st_r         <= '0;
            at_r         <= '0;
            td_r         <= '0;
            res_r        <= '0;
            o_we         <= 1'b0;
            o_st         <= '0;
            o_at         <= '0;
            o_data       <= '0;
            o_max_action <= '0;
            o_busy       <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            if (i_valid && (state != IDLE || o_busy)) o_overrun <= 1'b1;
            case (state)
                IDLE: begin
                    o_we <= 1'b0;
                    if (i_valid && !o_busy) begin
                        q_r    <= i_q;
                        nq_r   <= i_next_q;
                        r_r    <= i_reward;
                        st_r   <= i_st;
                        at_r   <= i_at;
                        max_q  <= i_next_q[(ACTIONS-1)*DATA_WIDTH +: DATA_WIDTH];
                        idx    <= '0;
                        cnt    <= ACTIONS_WIDTH'(1);
                        o_busy <= 1'b1;
                        state  <= MAX;
                    end else begin
                        o_busy <= 1'b0;
                    end
                end
                MAX: begin
                    if (row[cnt] > max_q) begin
                        max_q <= row[cnt];
                        idx   <= cnt;
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= TD;
                end
                TD: begin
                    td_r  <= td_next;
                    state <= SCALE;
                end
                SCALE: begin
                    res_r <= sat;
                    state <= WRITE;
                end
                WRITE: begin
                    o_we         <= 1'b1;
                    o_st         <= st_r;
                    o_at         <= at_r;
                    o_data       <= res_r;
                    o_max_action <= idx;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_q_update_unit.sv
// Directed bench for q_update_unit: hand-computed TD updates, saturation,
// truncation, overrun handling and asynchronous reset mid-update.
module tb_q_update_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic [15:0] i_q = '0;
    logic [63:0] i_next_q = '0;
    logic [15:0] i_reward = '0;
    logic [3:0]  i_st = '0;
    logic [1:0]  i_at = '0;
    logic        o_we;
    logic [3:0]  o_st;
    logic [1:0]  o_at;
    logic [15:0] o_data;
    logic [1:0]  o_max_action;
    logic        o_busy;
    logic        o_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    q_update_unit dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_q(i_q),
        .i_next_q(i_next_q), .i_reward(i_reward), .i_st(i_st), .i_at(i_at),
        .o_we(o_we), .o_st(o_st), .o_at(o_at), .o_data(o_data),
        .o_max_action(o_max_action), .o_busy(o_busy), .o_overrun(o_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One update: drive, accept, wait for write, check outputs and latency.
    // inj: fire a stray i_valid two cycles after acceptance and another in the
    // post-write cycle; both must be ignored.
    task automatic run_update(input string tag, input logic [15:0] q, input logic [63:0] nq,
                              input logic [15:0] r, input logic [3:0] s, input logic [1:0] a,
                              input logic [15:0] exp_d, input logic [1:0] exp_m, input bit inj);
        int lat;
        bit seen;
        @(negedge clk);
        i_q = q; i_next_q = nq; i_reward = r; i_st = s; i_at = a; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        check({tag, " busy_rise"}, 32'(o_busy), 32'd1);
        lat = 0; seen = 1'b0;
        while (lat < 20 && !seen) begin
            if (inj && lat == 1) begin
                i_q = 16'h1234; i_next_q = {4{16'h4000}}; i_reward = 16'h2000;
                i_st = 4'hF; i_at = 2'd3; i_valid = 1'b1;
            end
            @(posedge clk); #1;
            i_valid = 1'b0;
            lat++;
            seen = o_we;
        end
        check({tag, " latency"}, 32'(lat), 32'd6);
        check({tag, " data"}, 32'(o_data), 32'(exp_d));
        check({tag, " st"}, 32'(o_st), 32'(s));
        check({tag, " at"}, 32'(o_at), 32'(a));
        check({tag, " max_action"}, 32'(o_max_action), 32'(exp_m));
        check({tag, " busy_in_write"}, 32'(o_busy), 32'd1);
        if (inj) i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        check({tag, " we_single"}, 32'(o_we), 32'd0);
        check({tag, " busy_fall"}, 32'(o_busy), 32'd0);
        check({tag, " data_hold"}, 32'(o_data), 32'(exp_d));
        if (inj) begin
            check({tag, " overrun"}, 32'(o_overrun), 32'd1);
            @(posedge clk); #1;
            check({tag, " late_valid_ignored"}, 32'(o_busy), 32'd0);
        end
    endtask

    initial begin
        int pulses;
        #12;
        check("reset we", 32'(o_we), 32'd0);
        check("reset data", 32'(o_data), 32'd0);
        check("reset busy", 32'(o_busy), 32'd0);
        check("reset overrun", 32'(o_overrun), 32'd0);
        check("reset st_at_max", {26'd0, o_st, o_max_action}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // max 0x0200 tie between actions 1 and 3 -> 1; td=0x1CC, d=0xE6
        run_update("basic", 16'h0100, {16'h0000, 16'h0200, 16'h0180, 16'h0200},
                   16'h0100, 4'd3, 2'd2, 16'h01E6, 2'd1, 1'b0);
        check("no overrun yet", 32'(o_overrun), 32'd0);
        // p=-230, td=-486, d=-243
        run_update("negative", 16'h0000, {4{16'hFF00}}, 16'hFF00, 4'd7, 2'd0,
                   16'hFF0D, 2'd0, 1'b0);
        // s = 0x7F00 + 14847 -> clamp high
        run_update("sat_hi", 16'h7F00, {16'h1000, 16'h7FFF, 16'h7FFF, 16'h0000},
                   16'h7FFF, 4'd9, 2'd1, 16'h7FFF, 2'd1, 1'b0);
        // s = -32768 - 14720 -> clamp low
        run_update("sat_lo", 16'h8000, {4{16'h8000}}, 16'h8000, 4'd1, 2'd3,
                   16'h8000, 2'd0, 1'b0);
        // td=-1 -> d floors to -1
        run_update("trunc", 16'h0000, {4{16'h0000}}, 16'hFFFF, 4'd2, 2'd1,
                   16'hFFFF, 2'd0, 1'b0);
        // max at last entry, most-negative entry 0; td=178, d=89
        run_update("last_max", 16'h0200, {16'h8000, 16'h0100, 16'hFF00, 16'h0300},
                   16'h0000, 4'd12, 2'd3, 16'h0259, 2'd3, 1'b0);
        // stray valids must not disturb the basic result
        run_update("overrun", 16'h0100, {16'h0000, 16'h0200, 16'h0180, 16'h0200},
                   16'h0100, 4'd5, 2'd1, 16'h01E6, 2'd1, 1'b1);
        run_update("after_overrun", 16'h0000, {4{16'hFF00}}, 16'hFF00, 4'd6, 2'd2,
                   16'hFF0D, 2'd0, 1'b0);
        check("overrun sticky", 32'(o_overrun), 32'd1);

        // async reset two cycles into MAX
        @(negedge clk);
        i_q = 16'h0100; i_next_q = {16'h0000, 16'h0200, 16'h0180, 16'h0200};
        i_reward = 16'h0100; i_st = 4'd3; i_at = 2'd2; i_valid = 1'b1;
        @(posedge clk); #1; i_valid = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b0; #1;
        check("rst we", 32'(o_we), 32'd0);
        check("rst data", 32'(o_data), 32'd0);
        check("rst st_at_max", {26'd0, o_st, o_max_action}, 32'd0);
        check("rst busy", 32'(o_busy), 32'd0);
        check("rst overrun", 32'(o_overrun), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (o_we) pulses++;
        end
        check("rst no write", 32'(pulses), 32'd0);
        run_update("post_reset", 16'h0100, {16'h0000, 16'h0200, 16'h0180, 16'h0200},
                   16'h0100, 4'd3, 2'd2, 16'h01E6, 2'd1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
